// File: rtl/rv_mem_arbiter_if.sv
// Bus bundle between rv_cpu (IM/DM ports), rv_mem_arbiter and the single-port RAM.
// Signal suffixes are from the arbiter's point of view (slave modport).
interface rv_mem_arbiter_if #(
    parameter int unsigned ADDR_BITS = 16
) ();
    // Instruction fetch port
    logic [31:0]          im_addr_i;
    logic                 im_rd_i;
    logic [31:0]          im_data_o;
    logic                 im_valid_o;
    // Data port
    logic [31:0]          dm_addr_i;
    logic [31:0]          dm_data_s_i;
    logic [3:0]           dm_data_select_i;
    logic                 dm_store_i;
    logic                 dm_load_i;
    logic [31:0]          dm_data_l_o;
    logic                 dm_store_done_o;
    logic                 dm_load_done_o;
    logic                 dm_ready_o;
    // RAM side
    logic [ADDR_BITS-3:0] ram_addr_o;
    logic                 ram_en_o;
    logic [3:0]           ram_we_o;
    logic [31:0]          ram_wdata_o;
    logic [31:0]          ram_rdata_i;
    // I/O output register
    logic [7:0]           io_o;

    modport slave (
        input  im_addr_i, im_rd_i,
        input  dm_addr_i, dm_data_s_i, dm_data_select_i, dm_store_i, dm_load_i,
        input  ram_rdata_i,
        output im_data_o, im_valid_o,
        output dm_data_l_o, dm_store_done_o, dm_load_done_o, dm_ready_o,
        output ram_addr_o, ram_en_o, ram_we_o, ram_wdata_o,
        output io_o
    );

    modport master (
        output im_addr_i, im_rd_i,
        output dm_addr_i, dm_data_s_i, dm_data_select_i, dm_store_i, dm_load_i,
        output ram_rdata_i,
        input  im_data_o, im_valid_o,
        input  dm_data_l_o, dm_store_done_o, dm_load_done_o, dm_ready_o,
        input  ram_addr_o, ram_en_o, ram_we_o, ram_wdata_o,
        input  io_o
    );
endinterface

// File: rtl/rv_mem_arbiter.sv
// Shares one 1-cycle-latency single-port RAM between the fetch and data ports and
// decodes an 8-bit I/O output register. Define RV_MEM_ARB_RR_EN for round-robin ties.
module rv_mem_arbiter #(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned IO_BIT    = 17
) (
    input logic                clk_i,
    input logic                rst_i,
    rv_mem_arbiter_if.slave    bus_io
);

`ifdef RV_MEM_ARB_RR_EN
    typedef enum logic {GrantIm = 1'b0, GrantDm = 1'b1} grant_e;
    grant_e last_grant_q, last_grant_d;
`endif

    logic       im_pend_q, im_pend_d;
    logic       dm_pend_q, dm_pend_d;
    logic       dm_io_q, dm_io_d;
    logic [7:0] io_q, io_d;

    logic dm_store, dm_load, dm_req, dm_is_io;
    logic im_elig, dm_elig, io_acc;
    logic grant_im, grant_dm;

    // Store wins when both store and load are (illegally) raised together.
    assign dm_store = bus_io.dm_store_i;
    assign dm_load  = bus_io.dm_load_i & ~bus_io.dm_store_i;
    assign dm_req   = bus_io.dm_store_i | bus_io.dm_load_i;
    assign dm_is_io = bus_io.dm_addr_i[IO_BIT];

    assign im_elig = ~rst_i & bus_io.im_rd_i & ~im_pend_q;
    assign dm_elig = ~rst_i & dm_req & ~dm_is_io & ~dm_pend_q;
    assign io_acc  = ~rst_i & dm_req & dm_is_io & ~dm_pend_q;

    always_comb begin
`ifdef RV_MEM_ARB_RR_EN
        last_grant_d = last_grant_q;
        grant_dm     = dm_elig & (~im_elig | (last_grant_q == GrantIm));
        if (im_elig && dm_elig) begin
            last_grant_d = grant_dm ? GrantDm : GrantIm;
        end
`else
        grant_dm = dm_elig;
`endif
        grant_im = im_elig & ~grant_dm;
    end

    // RAM request mux: at most one port drives the RAM per cycle.
    always_comb begin
        bus_io.ram_en_o    = 1'b0;
        bus_io.ram_we_o    = 4'b0000;
        bus_io.ram_addr_o  = bus_io.im_addr_i[ADDR_BITS-1:2];
        bus_io.ram_wdata_o = bus_io.dm_data_s_i;
        if (grant_dm) begin
            bus_io.ram_en_o   = 1'b1;
            bus_io.ram_addr_o = bus_io.dm_addr_i[ADDR_BITS-1:2];
            bus_io.ram_we_o   = dm_store ? bus_io.dm_data_select_i : 4'b0000;
        end else if (grant_im) begin
            bus_io.ram_en_o = 1'b1;
        end
    end

    always_comb begin
        im_pend_d = grant_im;
        dm_pend_d = (grant_dm | io_acc) & dm_load;
        dm_io_d   = io_acc & dm_load;
        io_d      = io_q;
        if (io_acc && dm_store) begin
            io_d = bus_io.dm_data_s_i[7:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            im_pend_q    <= 1'b0;
            dm_pend_q    <= 1'b0;
            dm_io_q      <= 1'b0;
            io_q         <= 8'h00;
`ifdef RV_MEM_ARB_RR_EN
            last_grant_q <= GrantIm;
`endif
        end else begin
            im_pend_q    <= im_pend_d;
            dm_pend_q    <= dm_pend_d;
            dm_io_q      <= dm_io_d;
            io_q         <= io_d;
`ifdef RV_MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus_io.im_valid_o      = im_pend_q;
    assign bus_io.im_data_o       = bus_io.ram_rdata_i;
    assign bus_io.dm_load_done_o  = dm_pend_q;
    assign bus_io.dm_data_l_o     = dm_io_q ? {24'h000000, io_q} : bus_io.ram_rdata_i;
    assign bus_io.dm_store_done_o = (grant_dm | io_acc) & dm_store;
    assign bus_io.dm_ready_o      = ~dm_pend_q;
    assign bus_io.io_o            = io_q;

    // High address bits alias onto RAM; byte-offset bits are not part of the word address.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus_io.im_addr_i[31:ADDR_BITS], bus_io.im_addr_i[1:0],
                                bus_io.dm_addr_i[31:ADDR_BITS], bus_io.dm_addr_i[1:0]};

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench for rv_mem_arbiter: behavioural RAM, response scoreboard queues,
// immediate-assertion checks.
module tb_rv_mem_arbiter;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] im_exp_q[$];
    logic [31:0] dm_exp_q[$];

    logic [31:0] mem [0:16383];
    logic [31:0] ram_q;

    rv_mem_arbiter_if #(.ADDR_BITS(16)) bus ();

    rv_mem_arbiter #(.ADDR_BITS(16), .IO_BIT(17)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM, 1-cycle read latency; preloaded while in reset.
    always @(posedge clk) begin
        if (rst) begin
            mem[0] <= 32'hDEAD0000;
            mem[1] <= 32'h01010101;
            mem[2] <= 32'h22222222;
            mem[4] <= 32'h00000013;
            mem[8] <= 32'h11223344;
            mem[9] <= 32'h00000000;
        end else if (bus.ram_en_o) begin
            if (|bus.ram_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.ram_we_o[b]) mem[bus.ram_addr_o][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
                end
            end else begin
                ram_q <= mem[bus.ram_addr_o];
            end
        end
    end
    assign bus.ram_rdata_i = ram_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Response monitor: every completion must match the oldest expected response.
    always @(negedge clk) begin
        if (bus.im_valid_o === 1'b1) begin
            if (im_exp_q.size() == 0) check("im_unexpected_valid", bus.im_valid_o, 32'd0);
            else check("im_data", bus.im_data_o, im_exp_q.pop_front());
        end
        if (bus.dm_load_done_o === 1'b1) begin
            if (dm_exp_q.size() == 0) check("dm_unexpected_done", bus.dm_load_done_o, 32'd0);
            else check("dm_load_data", bus.dm_data_l_o, dm_exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch 0x10 and load dm_addr tie; winner gets the first cycle, loser the next.
    task automatic tie_round(input logic [31:0] dm_addr, input logic [31:0] dm_data,
                             input bit dm_first);
        tick();
        bus.im_rd_i   = 1'b1;
        bus.im_addr_i = 32'h10;
        bus.dm_load_i = 1'b1;
        bus.dm_addr_i = dm_addr;
        im_exp_q.push_back(32'h00000013);
        dm_exp_q.push_back(dm_data);
        @(negedge clk);
        check("tie_first_addr", bus.ram_addr_o, dm_first ? dm_addr >> 2 : 32'd4);
        tick();
        @(negedge clk);
        check("tie_second_en", bus.ram_en_o, 32'd1);
        check("tie_second_addr", bus.ram_addr_o, dm_first ? 32'd4 : dm_addr >> 2);
        check("tie_first_dm_done", bus.dm_load_done_o, dm_first ? 32'd1 : 32'd0);
        check("tie_first_im_valid", bus.im_valid_o, dm_first ? 32'd0 : 32'd1);
        tick();
        if (dm_first) bus.dm_load_i = 1'b0;
        else bus.im_rd_i = 1'b0;
        @(negedge clk);
        check("tie_loser_done", bus.im_valid_o | bus.dm_load_done_o, 32'd1);
        tick();
        bus.im_rd_i   = 1'b0;
        bus.dm_load_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst                  = 1'b1;
        bus.im_addr_i        = '0;
        bus.im_rd_i          = 1'b0;
        bus.dm_addr_i        = '0;
        bus.dm_data_s_i      = '0;
        bus.dm_data_select_i = '0;
        bus.dm_store_i       = 1'b0;
        bus.dm_load_i        = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_im_valid", bus.im_valid_o, 32'd0);
        check("rst_ram_en", bus.ram_en_o, 32'd0);
        check("rst_ram_we", bus.ram_we_o, 32'd0);
        check("rst_dm_ready", bus.dm_ready_o, 32'd1);
        check("rst_io", bus.io_o, 32'h00);
        check("rst_store_done", bus.dm_store_done_o, 32'd0);
        check("rst_load_done", bus.dm_load_done_o, 32'd0);

        // Reset mid-fetch: granted fetch must never complete.
        tick();
        rst           = 1'b0;
        bus.im_rd_i   = 1'b1;
        bus.im_addr_i = 32'h10;
        @(negedge clk);
        check("t1_grant", bus.ram_en_o, 32'd1);
        rst = 1'b1;
        #1;
        check("t1_en_in_reset", bus.ram_en_o, 32'd0);
        tick();
        check("t1_no_valid", bus.im_valid_o, 32'd0);
        bus.im_rd_i = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t1_no_valid_after", bus.im_valid_o, 32'd0);
        check("t1_io", bus.io_o, 32'h00);

        // Plain fetch from 0x10.
        tick();
        bus.im_rd_i   = 1'b1;
        bus.im_addr_i = 32'h10;
        im_exp_q.push_back(32'h00000013);
        @(negedge clk);
        check("t2_en", bus.ram_en_o, 32'd1);
        check("t2_addr", bus.ram_addr_o, 32'd4);
        check("t2_we", bus.ram_we_o, 32'd0);
        tick();
        @(negedge clk);
        check("t2_valid", bus.im_valid_o, 32'd1);
        check("t2_no_regrant", bus.ram_en_o, 32'd0);
        tick();
        bus.im_rd_i = 1'b0;

        // Byte-1 store to 0x20 then load back.
        bus.dm_addr_i        = 32'h20;
        bus.dm_data_s_i      = 32'hA5A5A5A5;
        bus.dm_data_select_i = 4'b0010;
        bus.dm_store_i       = 1'b1;
        @(negedge clk);
        check("t3_store_done", bus.dm_store_done_o, 32'd1);
        check("t3_we", bus.ram_we_o, 32'b0010);
        check("t3_addr", bus.ram_addr_o, 32'd8);
        tick();
        bus.dm_store_i = 1'b0;
        bus.dm_load_i  = 1'b1;
        dm_exp_q.push_back(32'h1122A544);
        @(negedge clk);
        check("t3_load_not_done", bus.dm_load_done_o, 32'd0);
        check("t3_ready_issue", bus.dm_ready_o, 32'd1);
        tick();
        @(negedge clk);
        check("t3_load_done", bus.dm_load_done_o, 32'd1);
        check("t3_ready_pend", bus.dm_ready_o, 32'd0);
        tick();
        bus.dm_load_i = 1'b0;

        // Repeated fetch/load ties.
`ifdef RV_MEM_ARB_RR_EN
        tie_round(32'h0, 32'hDEAD0000, 1'b1);
        tie_round(32'h4, 32'h01010101, 1'b0);
        tie_round(32'h8, 32'h22222222, 1'b1);
`else
        tie_round(32'h0, 32'hDEAD0000, 1'b1);
        tie_round(32'h4, 32'h01010101, 1'b1);
        tie_round(32'h8, 32'h22222222, 1'b1);
`endif

        // I/O store during a fetch, then I/O load.
        tick();
        bus.im_rd_i          = 1'b1;
        bus.im_addr_i        = 32'h10;
        im_exp_q.push_back(32'h00000013);
        bus.dm_addr_i        = 32'h20000;
        bus.dm_data_s_i      = 32'h0000005A;
        bus.dm_data_select_i = 4'b0000;
        bus.dm_store_i       = 1'b1;
        @(negedge clk);
        check("t5_store_done", bus.dm_store_done_o, 32'd1);
        check("t5_fetch_addr", bus.ram_addr_o, 32'd4);
        check("t5_we", bus.ram_we_o, 32'd0);
        check("t5_io_before", bus.io_o, 32'h00);
        tick();
        bus.dm_store_i = 1'b0;
        @(negedge clk);
        check("t5_io_after", bus.io_o, 32'h5A);
        check("t5_fetch_valid", bus.im_valid_o, 32'd1);
        tick();
        bus.im_rd_i   = 1'b0;
        bus.dm_load_i = 1'b1;
        dm_exp_q.push_back(32'h0000005A);
        @(negedge clk);
        check("t5_io_no_ram", bus.ram_en_o, 32'd0);
        check("t5_io_not_done", bus.dm_load_done_o, 32'd0);
        tick();
        @(negedge clk);
        check("t5_io_done", bus.dm_load_done_o, 32'd1);
        tick();
        bus.dm_load_i = 1'b0;

        // Back-to-back loads, one completion every second cycle.
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.dm_addr_i = 32'(4 * i);
            bus.dm_load_i = 1'b1;
            case (i)
                0:       dm_exp_q.push_back(32'hDEAD0000);
                1:       dm_exp_q.push_back(32'h01010101);
                default: dm_exp_q.push_back(32'h22222222);
            endcase
            @(negedge clk);
            check("t6_issue_en", bus.ram_en_o, 32'd1);
            check("t6_issue_not_done", bus.dm_load_done_o, 32'd0);
            tick();
            @(negedge clk);
            check("t6_done", bus.dm_load_done_o, 32'd1);
        end
        tick();
        bus.dm_load_i = 1'b0;

        // Store and load together: store wins, no load response.
        bus.dm_addr_i        = 32'h24;
        bus.dm_data_s_i      = 32'hCAFEF00D;
        bus.dm_data_select_i = 4'b1111;
        bus.dm_store_i       = 1'b1;
        bus.dm_load_i        = 1'b1;
        @(negedge clk);
        check("both_store_done", bus.dm_store_done_o, 32'd1);
        check("both_we", bus.ram_we_o, 32'b1111);
        tick();
        bus.dm_store_i = 1'b0;
        bus.dm_load_i  = 1'b0;
        @(negedge clk);
        check("both_no_load_done", bus.dm_load_done_o, 32'd0);

        // Load through an aliased address (bit 16 set, not the I/O bit).
        tick();
        bus.dm_addr_i = 32'h10024;
        bus.dm_load_i = 1'b1;
        dm_exp_q.push_back(32'hCAFEF00D);
        @(negedge clk);
        check("alias_addr", bus.ram_addr_o, 32'd9);
        tick();
        @(negedge clk);
        check("alias_done", bus.dm_load_done_o, 32'd1);
        tick();
        bus.dm_load_i = 1'b0;

        repeat (2) tick();
        check("im_queue_empty", im_exp_q.size(), 32'd0);
        check("dm_queue_empty", dm_exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
